mem_stage: RTL and testbench
============================

Name: mem_stage

Overview:
Memory stage of the 36-instruction 5-stage MIPS pipeline. It sits directly downstream of the execute stage and contains the EX/MEM pipeline register and a word-organised data memory with byte and halfword lane handling. It drives the MEM-to-EX forwarding value and the values consumed by writeback.

Parameters:
ADDR_W, 10, word-address width; memory holds 2**ADDR_W 32-bit words and is indexed by Mem_alure[ADDR_W+1:2].

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous, active-high reset
stall  input  1  hold the EX/MEM register
flush  input  1  load a bubble into EX/MEM
EX_PC  input  30  PC[31:2] of the EX instruction
EX_op  input  6  opcode of the EX instruction
alure  input  32  ALU result from EX, used as the effective address
EX_busB  input  32  store data (rt value)
EX_Reg  input  5  destination register
EX_RegWr, EX_MemWr, EX_MemtoReg, EX_MemRead  input  1 each  control signals from EX
Mem_PC  output  30  registered PC
Mem_alure  output  32  registered ALU result; this is the MEM forwarding source
Mem_Reg  output  5  registered destination register
Mem_RegWr  output  1  registered RegWr, forced to 0 on an address error
Mem_MemtoReg  output  1  registered MemtoReg
Mem_MemRead  output  1  registered MemRead, used by the hazard unit for load-use detection
Mem_dout  output  32  load data after lane extraction and extension
Mem_addr_err  output  1  misaligned access in MEM this cycle

Behaviour:
- EX/MEM register updates on posedge clk. Priority is rst > flush > stall > load.
- rst (async): all Mem_* registers go to 0, Mem_valid goes to 0. The memory array is not cleared.
- flush: Mem_valid=0 and every control register = 0. Data registers are don't-care.
- stall without flush: every register holds its value.
- Otherwise: capture all EX_* inputs and set Mem_valid=1.
- Internal opcode register Mem_op is captured with the other registers.
- Supported loads: lb 100000, lh 100001, lw 100011, lbu 100100, lhu 100101.
- Supported stores: sb 101000, sh 101001, sw 101011.
- Byte order is little-endian: Mem_alure[1:0]=00 selects bits 7:0.
- Address error is combinational: Mem_addr_err = Mem_valid & (MemRead|MemWr) & ((lh/lhu/sh & a[0]) | (lw/sw & a[1:0]!=0)).
- Store: on posedge clk, if Mem_valid & Mem_MemWr & !Mem_addr_err & !rst, write the addressed word using byte enables:
  - sw: all four lanes.
  - sh: lanes {a[1],0} and {a[1],1}, written with busB[15:0].
  - sb: lane a[1:0], written with busB[7:0].
  - Unselected lanes are unchanged.
- A store held by stall rewrites the same data each cycle. This is idempotent and permitted.
- Load: asynchronous read of the addressed word in the same cycle, so Mem_dout is valid in the cycle the instruction is in MEM.
  - lb/lh: sign-extend; lbu/lhu: zero-extend; lw: full word.
  - Mem_dout = 0 when not a load or when Mem_addr_err.
- A load in MEM that reads the word being stored in the same cycle sees the old contents. Back-to-back sw then lw to the same address sees the new data, because the write lands at the end of the sw's MEM cycle.
- Address bits above ADDR_W+1 are ignored, so addresses alias and wrap.
- Mem_RegWr output = registered RegWr & !Mem_addr_err.
- Latency: EX output to Mem_* outputs is 1 cycle. Load data is available combinationally in that same MEM cycle.

Decomposition:
- Shared include mips_defs.v holds the opcode constants (OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU, OP_SB, OP_SH, OP_SW) and the lane-select encodings, reused by the decoder and EX.
- One sub-module, mem_load_ext. It is combinational: word, a[1:0] and op in, extended Mem_dout out.
- Store byte-enable generation and the array stay in mem_stage.

Test Plan:
- sw 0x11223344 to 0x10, then lw 0x10 next cycle -> Mem_dout=0x11223344, Mem_RegWr=1, Mem_MemtoReg=1.
- sb 0xAA to 0x21, then lw 0x20 (word previously 0) -> Mem_dout=0x0000AA00. lb 0x21 -> 0xFFFFFFAA. lbu 0x21 -> 0x000000AA.
- sh 0x8001 to 0x32, then lh 0x32 -> 0xFFFF8001. lhu 0x32 -> 0x00008001. lw 0x30 -> 0x80010000.
- lw at 0x13 and sh at 0x05 -> Mem_addr_err=1, Mem_RegWr=0, Mem_dout=0. Word at 0x04 is unchanged on readback.
- Stall for 3 cycles with a new EX instruction waiting -> Mem_* outputs unchanged for those 3 cycles. Flush with stall=1 -> bubble: Mem_RegWr=0 and no memory write.
- rst asserted mid-cycle while an sw is in MEM -> all Mem_* outputs go to 0 immediately (asynchronous) and the store does not occur. On release, a fresh instruction is captured normally.

Source files
------------

// File: rtl/mem_stage_pkg.sv
// Opcode constants and access-size helpers shared by the MEM stage and its load extractor.
package mem_stage_pkg;

    localparam logic [5:0] OP_LB  = 6'b100000;
    localparam logic [5:0] OP_LH  = 6'b100001;
    localparam logic [5:0] OP_LW  = 6'b100011;
    localparam logic [5:0] OP_LBU = 6'b100100;
    localparam logic [5:0] OP_LHU = 6'b100101;
    localparam logic [5:0] OP_SB  = 6'b101000;
    localparam logic [5:0] OP_SH  = 6'b101001;
    localparam logic [5:0] OP_SW  = 6'b101011;

    typedef enum logic [1:0] {
        SZ_B = 2'd0,
        SZ_H = 2'd1,
        SZ_W = 2'd2
    } mem_size_e;

    function automatic mem_size_e op_size(input logic [5:0] op);
        case (op)
            OP_LW, OP_SW:         return SZ_W;
            OP_LH, OP_LHU, OP_SH: return SZ_H;
            default:              return SZ_B;
        endcase
    endfunction

    function automatic logic is_load(input logic [5:0] op);
        return (op == OP_LB) || (op == OP_LH) || (op == OP_LW) ||
               (op == OP_LBU) || (op == OP_LHU);
    endfunction

    function automatic logic is_store(input logic [5:0] op);
        return (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
    endfunction

endpackage

// File: rtl/mem_load_ext.sv
// Picks the addressed byte/halfword out of a little-endian word and sign/zero extends it.
module mem_load_ext
    import mem_stage_pkg::*;
(
    input  logic [31:0] word_i,
    input  logic [1:0]  a_i,
    input  logic [5:0]  op_i,
    output logic [31:0] dout_o
);

    logic [7:0]  byte_w;
    logic [15:0] half_w;

    always_comb begin
        case (a_i)
            2'd0:    byte_w = word_i[7:0];
            2'd1:    byte_w = word_i[15:8];
            2'd2:    byte_w = word_i[23:16];
            default: byte_w = word_i[31:24];
        endcase
        half_w = a_i[1] ? word_i[31:16] : word_i[15:0];
    end

    always_comb begin
        dout_o = 32'd0;
        case (op_i)
            OP_LB:   dout_o = {{24{byte_w[7]}}, byte_w};
            OP_LBU:  dout_o = {24'd0, byte_w};
            OP_LH:   dout_o = {{16{half_w[15]}}, half_w};
            OP_LHU:  dout_o = {16'd0, half_w};
            OP_LW:   dout_o = word_i;
            default: dout_o = 32'd0;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// MIPS MEM stage: EX/MEM pipeline register plus byte-enabled word data memory.
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int ADDR_W = 10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        flush,
    input  logic [29:0] EX_PC,
    input  logic [5:0]  EX_op,
    input  logic [31:0] alure,
    input  logic [31:0] EX_busB,
    input  logic [4:0]  EX_Reg,
    input  logic        EX_RegWr,
    input  logic        EX_MemWr,
    input  logic        EX_MemtoReg,
    input  logic        EX_MemRead,
    output logic [29:0] Mem_PC,
    output logic [31:0] Mem_alure,
    output logic [4:0]  Mem_Reg,
    output logic        Mem_RegWr,
    output logic        Mem_MemtoReg,
    output logic        Mem_MemRead,
    output logic [31:0] Mem_dout,
    output logic        Mem_addr_err
);

    logic [29:0] pc_q;
    logic [5:0]  op_q;
    logic [31:0] alure_q, busb_q;
    logic [4:0]  reg_q;
    logic        regwr_q, memwr_q, memtoreg_q, memread_q, valid_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q       <= '0;
            op_q       <= '0;
            alure_q    <= '0;
            busb_q     <= '0;
            reg_q      <= '0;
            regwr_q    <= 1'b0;
            memwr_q    <= 1'b0;
            memtoreg_q <= 1'b0;
            memread_q  <= 1'b0;
            valid_q    <= 1'b0;
        end else if (flush) begin
            regwr_q    <= 1'b0;
            memwr_q    <= 1'b0;
            memtoreg_q <= 1'b0;
            memread_q  <= 1'b0;
            valid_q    <= 1'b0;
        end else if (!stall) begin
            pc_q       <= EX_PC;
            op_q       <= EX_op;
            alure_q    <= alure;
            busb_q     <= EX_busB;
            reg_q      <= EX_Reg;
            regwr_q    <= EX_RegWr;
            memwr_q    <= EX_MemWr;
            memtoreg_q <= EX_MemtoReg;
            memread_q  <= EX_MemRead;
            valid_q    <= 1'b1;
        end
    end

    logic [ADDR_W-1:0] idx;
    logic [1:0]        a_lo;
    mem_size_e         sz;
    logic              addr_err;

    assign idx  = alure_q[ADDR_W+1:2];
    assign a_lo = alure_q[1:0];
    assign sz   = op_size(op_q);
    assign addr_err = valid_q & (memread_q | memwr_q) &
                      (((sz == SZ_H) & a_lo[0]) | ((sz == SZ_W) & (a_lo != 2'b00)));

    // Store data is replicated across lanes so the byte enables alone pick the target.
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        we;

    always_comb begin
        be    = 4'b0000;
        wdata = busb_q;
        case (sz)
            SZ_W: be = 4'b1111;
            SZ_H: begin
                be    = a_lo[1] ? 4'b1100 : 4'b0011;
                wdata = {2{busb_q[15:0]}};
            end
            default: begin
                be    = 4'b0001 << a_lo;
                wdata = {4{busb_q[7:0]}};
            end
        endcase
    end

    assign we = valid_q & memwr_q & ~addr_err & ~rst & is_store(op_q);

    logic [31:0] mem_q [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) mem_q[idx][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
    end

    logic [31:0] rdata, ext;
    logic        ld_ok;

    assign rdata = mem_q[idx];
    assign ld_ok = valid_q & memread_q & ~addr_err & is_load(op_q);

    mem_load_ext u_ext (
        .word_i (rdata),
        .a_i    (a_lo),
        .op_i   (op_q),
        .dout_o (ext)
    );

    assign Mem_PC       = pc_q;
    assign Mem_alure    = alure_q;
    assign Mem_Reg      = reg_q;
    assign Mem_RegWr    = regwr_q & ~addr_err;
    assign Mem_MemtoReg = memtoreg_q;
    assign Mem_MemRead  = memread_q;
    assign Mem_dout     = ld_ok ? ext : 32'd0;
    assign Mem_addr_err = addr_err;

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: loads/stores, lane handling, address errors, stall/flush, async reset.
module tb_mem_stage;

    localparam logic [5:0] LB = 6'b100000, LH = 6'b100001, LW = 6'b100011;
    localparam logic [5:0] LBU = 6'b100100, LHU = 6'b100101;
    localparam logic [5:0] SB = 6'b101000, SH = 6'b101001, SW = 6'b101011;

    logic        clk = 1'b0, rst = 1'b1, stall = 1'b0, flush = 1'b0;
    logic [29:0] EX_PC = '0;
    logic [5:0]  EX_op = '0;
    logic [31:0] alure = '0, EX_busB = '0;
    logic [4:0]  EX_Reg = '0;
    logic        EX_RegWr = 0, EX_MemWr = 0, EX_MemtoReg = 0, EX_MemRead = 0;
    logic [29:0] Mem_PC;
    logic [31:0] Mem_alure, Mem_dout;
    logic [4:0]  Mem_Reg;
    logic        Mem_RegWr, Mem_MemtoReg, Mem_MemRead, Mem_addr_err;

    int checks = 0, errors = 0;

    mem_stage #(.ADDR_W(10)) dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush),
        .EX_PC(EX_PC), .EX_op(EX_op), .alure(alure), .EX_busB(EX_busB), .EX_Reg(EX_Reg),
        .EX_RegWr(EX_RegWr), .EX_MemWr(EX_MemWr), .EX_MemtoReg(EX_MemtoReg), .EX_MemRead(EX_MemRead),
        .Mem_PC(Mem_PC), .Mem_alure(Mem_alure), .Mem_Reg(Mem_Reg), .Mem_RegWr(Mem_RegWr),
        .Mem_MemtoReg(Mem_MemtoReg), .Mem_MemRead(Mem_MemRead), .Mem_dout(Mem_dout),
        .Mem_addr_err(Mem_addr_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Put an instruction on the EX inputs; control bits follow from the opcode.
    task automatic ex(input logic [29:0] pc, input logic [5:0] op, input logic [31:0] addr,
                      input logic [31:0] data, input logic [4:0] rd);
        logic ld, st;
        ld = (op[5:3] == 3'b100);
        st = (op[5:3] == 3'b101);
        EX_PC = pc; EX_op = op; alure = addr; EX_busB = data; EX_Reg = rd;
        EX_RegWr = ld; EX_MemtoReg = ld; EX_MemRead = ld; EX_MemWr = st;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2;
        chk("rst_pc", {2'b0, Mem_PC}, 32'd0);
        chk("rst_alure", Mem_alure, 32'd0);
        chk("rst_regwr", {31'd0, Mem_RegWr}, 32'd0);
        chk("rst_memread", {31'd0, Mem_MemRead}, 32'd0);
        chk("rst_dout", Mem_dout, 32'd0);
        chk("rst_err", {31'd0, Mem_addr_err}, 32'd0);
        step();
        rst = 1'b0;

        ex(30'h10, SW, 32'h10, 32'h11223344, 5'd0); step();
        chk("sw_regwr", {31'd0, Mem_RegWr}, 32'd0);
        chk("sw_dout", Mem_dout, 32'd0);
        ex(30'h11, LW, 32'h10, 32'h0, 5'd3); step();
        chk("lw10_dout", Mem_dout, 32'h11223344);
        chk("lw10_regwr", {31'd0, Mem_RegWr}, 32'd1);
        chk("lw10_memtoreg", {31'd0, Mem_MemtoReg}, 32'd1);
        chk("lw10_pc", {2'b0, Mem_PC}, 32'h11);

        // Known contents for the words touched by partial stores / error readback.
        ex(30'h12, SW, 32'h20, 32'h0, 5'd0); step();
        ex(30'h13, SW, 32'h30, 32'h0, 5'd0); step();
        ex(30'h14, SW, 32'h04, 32'hCAFEBABE, 5'd0); step();

        ex(30'h15, SB, 32'h21, 32'h123456AA, 5'd0); step();
        ex(30'h16, LW, 32'h20, 32'h0, 5'd4); step();
        chk("sb_lw20", Mem_dout, 32'h0000AA00);
        ex(30'h17, LB, 32'h21, 32'h0, 5'd4); step();
        chk("lb21", Mem_dout, 32'hFFFFFFAA);
        ex(30'h18, LBU, 32'h21, 32'h0, 5'd4); step();
        chk("lbu21", Mem_dout, 32'h000000AA);

        ex(30'h19, SH, 32'h32, 32'hFFFF8001, 5'd0); step();
        ex(30'h1A, LH, 32'h32, 32'h0, 5'd5); step();
        chk("lh32", Mem_dout, 32'hFFFF8001);
        ex(30'h1B, LHU, 32'h32, 32'h0, 5'd5); step();
        chk("lhu32", Mem_dout, 32'h00008001);
        ex(30'h1C, LW, 32'h30, 32'h0, 5'd5); step();
        chk("lw30", Mem_dout, 32'h80010000);
        // Upper address bits beyond the array wrap onto the same word.
        ex(30'h1D, LW, 32'h00001030, 32'h0, 5'd5); step();
        chk("lw_alias", Mem_dout, 32'h80010000);

        ex(30'h1E, LW, 32'h13, 32'h0, 5'd6); step();
        chk("lw13_err", {31'd0, Mem_addr_err}, 32'd1);
        chk("lw13_regwr", {31'd0, Mem_RegWr}, 32'd0);
        chk("lw13_dout", Mem_dout, 32'd0);
        ex(30'h1F, SH, 32'h05, 32'h0000FFFF, 5'd0); step();
        chk("sh05_err", {31'd0, Mem_addr_err}, 32'd1);
        ex(30'h20, LW, 32'h04, 32'h0, 5'd6); step();
        chk("lw04_keep", Mem_dout, 32'hCAFEBABE);
        chk("lw04_err", {31'd0, Mem_addr_err}, 32'd0);

        ex(30'h100, LW, 32'h10, 32'h0, 5'd7); step();
        chk("pre_stall", Mem_dout, 32'h11223344);
        stall = 1'b1;
        ex(30'h200, LW, 32'h30, 32'h0, 5'd9);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("stall_pc", {2'b0, Mem_PC}, 32'h100);
            chk("stall_reg", {27'd0, Mem_Reg}, 32'd7);
            chk("stall_dout", Mem_dout, 32'h11223344);
        end
        flush = 1'b1;
        ex(30'h201, SW, 32'h10, 32'hDEADBEEF, 5'd0); step();
        chk("flush_regwr", {31'd0, Mem_RegWr}, 32'd0);
        chk("flush_memread", {31'd0, Mem_MemRead}, 32'd0);
        chk("flush_dout", Mem_dout, 32'd0);
        step();
        stall = 1'b0; flush = 1'b0;
        ex(30'h202, LW, 32'h10, 32'h0, 5'd8); step();
        chk("post_flush_lw", Mem_dout, 32'h11223344);

        ex(30'h300, SW, 32'h10, 32'h55555555, 5'd0); step();
        #2 rst = 1'b1;
        #1;
        chk("arst_pc", {2'b0, Mem_PC}, 32'd0);
        chk("arst_alure", Mem_alure, 32'd0);
        chk("arst_reg", {27'd0, Mem_Reg}, 32'd0);
        chk("arst_memread", {31'd0, Mem_MemRead}, 32'd0);
        ex(30'h301, LW, 32'h10, 32'h0, 5'd2);
        step();
        #3 rst = 1'b0;
        step();
        chk("post_rst_pc", {2'b0, Mem_PC}, 32'h301);
        chk("post_rst_lw", Mem_dout, 32'h11223344);
        chk("post_rst_regwr", {31'd0, Mem_RegWr}, 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
